// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular FIFO between Fetch and Decode.
// Filters cache-miss fetches (counted, saturating) and empties on a taken-branch flush.
module if_id_queue #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_hit,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_next_pc,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       stall,
  output logic                       out_valid,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_next_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           miss_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    next_pc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop, miss;

  // MSB of each pointer is a wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign in_ready  = !full;
  assign out_valid = !empty;

  assign push = in_valid &  in_hit & in_ready & !flush;
  assign miss = in_valid & !in_hit & !flush;
  assign pop  = out_valid & !stall & !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      miss_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      // Flush drops everything queued; the concurrent push is already gated off.
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (miss && (miss_cnt != {CNT_W{1'b1}})) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  // Storage has no reset; only pointer state defines validity.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr[AW-1:0]] <= '{instr: in_instr, next_pc: in_next_pc};
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign out_instr   = empty ? '0 : head.instr;
  assign out_next_pc = empty ? '0 : head.next_pc;
  assign count       = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: stimulus pushes expected entries, a monitor
// checks every pop against them in FIFO order.
module tb_if_id_queue;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_hit, flush, stall;
  logic [31:0] in_instr, in_next_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_instr, out_next_pc;
  logic [2:0]  count;
  logic [15:0] miss_cnt;
  logic        in_ready2, out_valid2;
  logic [31:0] out_instr2, out_next_pc2;
  logic [2:0]  count2;
  logic [1:0]  miss_cnt2;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit),
    .in_instr(in_instr), .in_next_pc(in_next_pc), .in_ready(in_ready),
    .flush(flush), .stall(stall), .out_valid(out_valid),
    .out_instr(out_instr), .out_next_pc(out_next_pc), .count(count),
    .miss_cnt(miss_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  if_id_queue #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit),
    .in_instr(in_instr), .in_next_pc(in_next_pc), .in_ready(in_ready2),
    .flush(flush), .stall(stall), .out_valid(out_valid2),
    .out_instr(out_instr2), .out_next_pc(out_next_pc2), .count(count2),
    .miss_cnt(miss_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic h, input logic [31:0] ins, input logic [31:0] pc);
    in_valid   = v;
    in_hit     = h;
    in_instr   = ins;
    in_next_pc = pc;
  endtask

  // Monitor: a pop happens at the next edge, so compare the head now.
  always @(negedge clk) begin
    if (!rst && out_valid && !stall && !flush) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h/%0h expected nothing", out_instr, out_next_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({out_instr, out_next_pc} !== e) begin
          fails++;
          $display("FAIL pop_data: got %0h/%0h expected %0h/%0h",
                   out_instr, out_next_pc, e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] vec [4];
    vec[0] = 32'h20080005; vec[1] = 32'h20090003;
    vec[2] = 32'h01095020; vec[3] = 32'hAC0A0000;
    rst = 1'b1; flush = 1'b0; stall = 1'b1;
    drive(1'b0, 1'b0, '0, '0);

    // 1: reset then fill with decode stalled
    tick(); tick();
    check("rst_count", count, 0);
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_ready", in_ready, 1);
    check("rst_miss", miss_cnt, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, vec[i], 32'h100 + 4 * (i + 1));
      exp_q.push_back({vec[i], 32'h100 + 4 * (i + 1)});
      tick();
    end
    check("fill_count", count, 4);
    check("fill_ready", in_ready, 0);
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h200);
    tick();
    check("full_reject_count", count, 4);
    check("full_head", out_instr, 32'h20080005);

    // 2: drain in order on consecutive cycles
    drive(1'b0, 1'b0, '0, '0);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_instr", out_instr, vec[i]);
      tick();
    end
    check("drain_empty_valid", out_valid, 0);
    check("drain_empty_instr", out_instr, 0);
    check("drain_empty_pc", out_next_pc, 0);

    // 3: back-to-back streaming across pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 32'h10000000 + i, 4 * (i + 1));
      exp_q.push_back({32'h10000000 + i, 32'(4 * (i + 1))});
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_next_pc, 4 * (i + 1));
      check("stream_count", count, 1);
    end
    drive(1'b0, 1'b0, '0, '0);
    tick();
    check("stream_done_count", count, 0);

    // 4: miss filtering and saturation
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i % 2) == 0, 32'h30000000 + i, 32'h400 + 4 * i);
      if ((i % 2) == 0) exp_q.push_back({32'h30000000 + i, 32'h400 + 4 * i});
      tick();
    end
    check("miss_count_q", count, 3);
    check("miss_cnt3", miss_cnt, 3);
    check("miss_cnt3_narrow", miss_cnt2, 3);
    drive(1'b1, 1'b0, 32'hFFFF0000, 0);
    tick(); tick();
    check("miss_cnt5", miss_cnt, 5);
    check("miss_sat_narrow", miss_cnt2, 3);
    drive(1'b0, 1'b0, '0, '0);
    stall = 1'b0;
    tick(); tick(); tick();
    check("miss_drained", out_valid, 0);

    // 5: flush with a concurrent push
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h40000000 + i, 32'h500 + 4 * i);
      exp_q.push_back({32'h40000000 + i, 32'h500 + 4 * i});
      tick();
    end
    check("preflush_count", count, 3);
    drive(1'b1, 1'b1, 32'h0BAD0BAD, 32'h666);
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_miss_kept", miss_cnt, 5);
    drive(1'b1, 1'b1, 32'h22222222, 32'h700);
    exp_q.push_back({32'h22222222, 32'h700});
    tick();
    drive(1'b0, 1'b0, '0, '0);
    check("postflush_head", out_instr, 32'h22222222);
    check("postflush_count", count, 1);
    stall = 1'b0;
    tick();

    // 6: reset wins over flush and push mid-stream
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 32'h50000000 + i, 32'h800 + 4 * i);
      exp_q.push_back({32'h50000000 + i, 32'h800 + 4 * i});
      tick();
    end
    check("prerst_count", count, 2);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 32'h77777777, 32'h900);
    exp_q.delete();
    tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    check("midrst_count", count, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_instr", out_instr, 0);
    check("midrst_pc", out_next_pc, 0);
    check("midrst_ready", in_ready, 1);
    check("midrst_miss", miss_cnt, 0);
    check("midrst_miss_narrow", miss_cnt2, 0);
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
